// File: rtl/fifo_ctrl_level_m.sv
// Single-clock FIFO pointer/status controller: wrap-bit pointers, qualified
// push/pop, registered occupancy and threshold flags, sticky errors, high-water mark.
module fifo_ctrl_level_m #(
    parameter int DEEPWID = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             clr_stat,
    input  logic [DEEPWID:0] cfg_almost_empty,
    input  logic [DEEPWID:0] cfg_almost_full,
    output logic [DEEPWID:0] wr_addr,
    output logic [DEEPWID:0] rd_addr,
    output logic             ram_we,
    output logic             ram_re,
    output logic [DEEPWID:0] fifo_num,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow,
    output logic [DEEPWID:0] high_water
);

    localparam int AW = DEEPWID + 1;
    localparam logic [DEEPWID:0] ZERO_C  = {AW{1'b0}};
    localparam logic [DEEPWID:0] ONE_C   = {{DEEPWID{1'b0}}, 1'b1};
    localparam logic [DEEPWID:0] DEPTH_C = {1'b1, {DEEPWID{1'b0}}};

    logic [DEEPWID:0] wr_ptr_r, rd_ptr_r, num_r, hw_r;
    logic             empty_r, full_r, ae_r, af_r, ovf_r, udf_r;

    logic [DEEPWID:0] wr_ptr_nxt_s, rd_ptr_nxt_s, num_nxt_s, hw_nxt_s;
    logic             ram_we_s, ram_re_s, ovf_nxt_s, udf_nxt_s;

    // Acceptance uses the registered flags so the RAM never sees an illegal access.
    always_comb begin
        ram_we_s = wr_en & ~full_r;
        ram_re_s = rd_en & ~empty_r;
    end

    // Next-state for pointers, occupancy, sticky errors and high-water mark.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        num_nxt_s    = num_r;
        hw_nxt_s     = hw_r;

        if (ram_we_s) begin
            wr_ptr_nxt_s = wr_ptr_r + ONE_C;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (ram_re_s) begin
            rd_ptr_nxt_s = rd_ptr_r + ONE_C;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        if (ram_we_s && !ram_re_s) begin
            num_nxt_s = num_r + ONE_C;
        end else if (!ram_we_s && ram_re_s) begin
            num_nxt_s = num_r - ONE_C;
        end else begin
            num_nxt_s = num_r;
        end

        // A set event in the same cycle as clr_stat keeps the flag asserted.
        ovf_nxt_s = (wr_en & full_r) | (ovf_r & ~clr_stat);
        udf_nxt_s = (rd_en & empty_r) | (udf_r & ~clr_stat);

        if (clr_stat) begin
            hw_nxt_s = num_nxt_s;
        end else if (num_nxt_s > hw_r) begin
            hw_nxt_s = num_nxt_s;
        end else begin
            hw_nxt_s = hw_r;
        end
    end

    // State registers; flags derive from num_nxt so they move with fifo_num.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= ZERO_C;
            rd_ptr_r <= ZERO_C;
            num_r    <= ZERO_C;
            hw_r     <= ZERO_C;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            ae_r     <= 1'b1;
            af_r     <= 1'b0;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            num_r    <= num_nxt_s;
            hw_r     <= hw_nxt_s;
            empty_r  <= (num_nxt_s == ZERO_C);
            full_r   <= (num_nxt_s == DEPTH_C);
            ae_r     <= (num_nxt_s <= cfg_almost_empty);
            af_r     <= (num_nxt_s >= cfg_almost_full);
            ovf_r    <= ovf_nxt_s;
            udf_r    <= udf_nxt_s;
        end
    end

    assign wr_addr      = wr_ptr_r;
    assign rd_addr      = rd_ptr_r;
    assign ram_we       = ram_we_s;
    assign ram_re       = ram_re_s;
    assign fifo_num     = num_r;
    assign empty        = empty_r;
    assign full         = full_r;
    assign almost_empty = ae_r;
    assign almost_full  = af_r;
    assign overflow     = ovf_r;
    assign underflow    = udf_r;
    assign high_water   = hw_r;

endmodule

// File: tb/tb_fifo_ctrl_level_m.sv
// Self-checking bench for fifo_ctrl_level_m: directed scenarios plus random
// push/pop traffic checked against a queue-based reference model.
module tb_fifo_ctrl_level_m;

    localparam int DW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0, rd_en = 1'b0, clr_stat = 1'b0;
    logic [DW:0]   cfg_almost_empty = 4'd2, cfg_almost_full = 4'd6;
    logic [DW:0]   wr_addr, rd_addr, fifo_num, high_water;
    logic          ram_we, ram_re, empty, full, almost_empty, almost_full, overflow, underflow;

    int checks = 0;
    int failures = 0;

    // Reference model: a queue of tokens plus counters of accepted operations.
    int          q[$];
    int          tok = 0;
    logic [DW:0] m_wp, m_rp;
    int          m_hw;
    logic        m_ovf, m_udf, m_ae, m_af;
    logic        obs_we, obs_re, exp_we, exp_re;

    fifo_ctrl_level_m #(.DEEPWID(DW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .clr_stat(clr_stat),
        .cfg_almost_empty(cfg_almost_empty), .cfg_almost_full(cfg_almost_full),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .ram_we(ram_we), .ram_re(ram_re),
        .fifo_num(fifo_num), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow),
        .high_water(high_water)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] exp_vec();
        int n;
        n = q.size();
        return {4'(n), m_wp, m_rp, 4'(m_hw), (n == 0), (n == DEPTH), m_ae, m_af, m_ovf, m_udf};
    endfunction

    function automatic logic [21:0] obs_vec();
        return {fifo_num, wr_addr, rd_addr, high_water, empty, full,
                almost_empty, almost_full, overflow, underflow};
    endfunction

    task automatic do_reset(input logic w, input logic r);
        @(negedge clk);
        rst_n = 1'b0; wr_en = w; rd_en = r; clr_stat = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        q.delete();
        m_wp = '0; m_rp = '0; m_hw = 0;
        m_ovf = 1'b0; m_udf = 1'b0; m_ae = 1'b1; m_af = 1'b0;
    endtask

    // One clock of stimulus; the model advances by the queue's own rules.
    task automatic cycle(input logic w, input logic r, input logic c);
        logic ovf_ev, udf_ev;
        int   n;
        @(negedge clk);
        wr_en = w; rd_en = r; clr_stat = c;
        #1;
        obs_we = ram_we; obs_re = ram_re;
        exp_we = w && (q.size() < DEPTH);
        exp_re = r && (q.size() > 0);
        ovf_ev = w && (q.size() == DEPTH);
        udf_ev = r && (q.size() == 0);
        if (exp_re) void'(q.pop_front());
        if (exp_we) begin q.push_back(tok); tok++; end
        if (exp_we) m_wp = m_wp + 4'd1;
        if (exp_re) m_rp = m_rp + 4'd1;
        n = q.size();
        m_ovf = ovf_ev || (m_ovf && !c);
        m_udf = udf_ev || (m_udf && !c);
        m_hw  = c ? n : ((n > m_hw) ? n : m_hw);
        m_ae  = (n <= int'(cfg_almost_empty));
        m_af  = (n >= int'(cfg_almost_full));
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_stat = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0);
        checks++;
        if (obs_vec() !== 22'({4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0})) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", obs_vec(),
                     22'({4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        end
        cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (fifo_num !== 4'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle num=%0d empty=%b ae=%b full=%b want 0/1/1/0",
                     fifo_num, empty, almost_empty, full);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            checks++;
            if (fifo_num !== 4'(i) || almost_full !== (i >= 6) || full !== (i == 8)) begin
                failures++;
                $display("FAIL fill_%0d num=%0d af=%b full=%b want %0d/%b/%b",
                         i, fifo_num, almost_full, full, i, (i >= 6), (i == 8));
            end
        end
        checks++;
        if (wr_addr !== 4'b1000 || high_water !== 4'd8) begin
            failures++;
            $display("FAIL fill_end wr_addr=%b hw=%0d want 1000/8", wr_addr, high_water);
        end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_we !== 1'b0 || wr_addr !== 4'b1000 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set we=%b wr_addr=%b ovf=%b want 0/1000/1", obs_we, wr_addr, overflow);
        end
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0 || high_water !== 4'd8) begin
            failures++;
            $display("FAIL overflow_clr ovf=%b hw=%0d want 0/8", overflow, high_water);
        end
    endtask

    task automatic test_push_pop();
        cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_re !== 1'b1 || obs_we !== 1'b0 || fifo_num !== 4'd7 || full !== 1'b0) begin
            failures++;
            $display("FAIL pushpop_full re=%b we=%b num=%0d full=%b want 1/0/7/0",
                     obs_re, obs_we, fifo_num, full);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_re !== 1'b1 || obs_we !== 1'b1 || fifo_num !== 4'd4 ||
            wr_addr !== 4'd9 || rd_addr !== 4'd5) begin
            failures++;
            $display("FAIL pushpop_mid re=%b we=%b num=%0d wr=%0d rd=%0d want 1/1/4/9/5",
                     obs_re, obs_we, fifo_num, wr_addr, rd_addr);
        end
    endtask

    task automatic test_drain();
        for (int k = 3; k >= 0; k--) begin
            cycle(1'b0, 1'b1, 1'b0);
            checks++;
            if (fifo_num !== 4'(k) || almost_empty !== (k <= 2) || empty !== (k == 0)) begin
                failures++;
                $display("FAIL drain_%0d num=%0d ae=%b empty=%b want %0d/%b/%b",
                         k, fifo_num, almost_empty, empty, k, (k <= 2), (k == 0));
            end
        end
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_re !== 1'b0 || underflow !== 1'b1 || rd_addr !== 4'd9) begin
            failures++;
            $display("FAIL underflow_set re=%b udf=%b rd=%0d want 0/1/9", obs_re, underflow, rd_addr);
        end
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clr udf=%b want 0", underflow);
        end
        cycle(1'b0, 1'b1, 1'b1);
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow_set_wins udf=%b want 1", underflow);
        end
    endtask

    task automatic test_thresholds();
        cfg_almost_full = 4'd0; cfg_almost_empty = 4'd8;
        do_reset(1'b0, 1'b0);
        checks++;
        if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL thr_reset af=%b ae=%b want 0/1", almost_full, almost_empty);
        end
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (almost_full !== 1'b1 || almost_empty !== 1'b1) begin
                failures++;
                $display("FAIL thr_const_%0d af=%b ae=%b want 1/1", i, almost_full, almost_empty);
            end
            cycle(1'b1, 1'b0, 1'b0);
        end
        cfg_almost_full = 4'd6; cfg_almost_empty = 4'd2;
        do_reset(1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic w, r, c;
        for (int i = 0; i < 120; i++) begin
            if (i == 60) begin
                do_reset(1'($urandom_range(1)), 1'($urandom_range(1)));
                checks++;
                if (obs_vec() !== 22'({4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0})) begin
                    failures++;
                    $display("FAIL rand_reset got=%h", obs_vec());
                end
            end
            w = ($urandom_range(99) < 70);
            r = ($urandom_range(99) < 55);
            c = ($urandom_range(99) < 10);
            cycle(w, r, c);
            checks++;
            if (obs_we !== exp_we || obs_re !== exp_re) begin
                failures++;
                $display("FAIL rand_accept_%0d we=%b re=%b want %b/%b", i, obs_we, obs_re, exp_we, exp_re);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rand_state_%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (4'(wr_addr - rd_addr) !== fifo_num) begin
                failures++;
                $display("FAIL rand_invariant_%0d wr-rd=%0d num=%0d", i, 4'(wr_addr - rd_addr), fifo_num);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_push_pop();
        test_drain();
        test_thresholds();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
